seq_8_detector: RTL and testbench

- Serial, programmable 8-bit sequence detector for the CAN controller bit-stream path.
- While `load` is high, the reference pattern is shifted in serially from `din`.
- While `load` is low, `din` is shifted into a history register. `dout` pulses when the last WIDTH received bits equal the stored pattern.
- Used to flag fixed bit sequences (e.g. delimiters, stuff/error patterns) on the received bit stream.

---
 rtl/can_seq_pkg.sv | 16 +
 rtl/seq_shift_reg.sv | 51 +++++
 rtl/seq_8_detector.sv | 69 ++++++
 tb/tb_seq_8_detector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/can_seq_pkg.sv
// Shared constants for the CAN bit-stream sequence detectors.
// Pattern widths and named fixed bit sequences.
package can_seq_pkg;

    localparam int SEQ_W = 8;

    localparam int STUFF_W = 6;
    localparam int EOF_W   = 7;

    // Six equal bits in a row break the stuffing rule
    localparam logic [STUFF_W-1:0] STUFF_ERR_DOM = '0;
    localparam logic [STUFF_W-1:0] STUFF_ERR_REC = '1;

    localparam logic [EOF_W-1:0] EOF_PAT = '1;

endpackage

// File: rtl/seq_shift_reg.sv
// Serial-in shift register with a saturating fill counter.
// o_full is high once WIDTH bits have been shifted since the last restart/clear.
module seq_shift_reg
    import can_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_W,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift,
    input  logic             i_restart,
    input  logic             i_clear,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;

    generate
        if (WIDTH == 1) begin : g_one
            assign w_data_next = i_bit;
        end else begin : g_many
            assign w_data_next = {r_data[WIDTH-2:0], i_bit};
        end
    endgenerate

    assign w_cnt_inc = (r_cnt == FULL) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= w_data_next;
            r_cnt  <= i_restart ? CW'(1) : w_cnt_inc;
        end
    end

    assign o_data = r_data;
    assign o_full = (r_cnt == FULL);

endmodule

// File: rtl/seq_8_detector.sv
// Programmable serial sequence detector: load a WIDTH-bit pattern
// serially, then pulse dout whenever the last WIDTH bits match it.
module seq_8_detector
    import can_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_W,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic din,
    output logic dout
);

    logic             r_load_q;
    logic             r_dout;
    logic [WIDTH-1:0] w_pat;
    logic             w_pat_full;
    logic [WIDTH-2:0] w_hist;
    logic             w_hist_full;
    logic             w_match;

    seq_shift_reg #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_pat (
        .clk       (clk),
        .rst       (rst),
        .i_shift   (load),
        .i_restart (~r_load_q),
        .i_clear   (1'b0),
        .i_bit     (din),
        .o_data    (w_pat),
        .o_full    (w_pat_full)
    );

    // The newest history bit is din itself, so WIDTH-1 stored bits suffice
    seq_shift_reg #(
        .WIDTH (WIDTH - 1)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .i_shift   (~load),
        .i_restart (1'b0),
        .i_clear   (load),
        .i_bit     (din),
        .o_data    (w_hist),
        .o_full    (w_hist_full)
    );

    assign w_match = ~load
                   & w_pat_full
                   & w_hist_full
                   & ({w_hist, din} == w_pat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_q <= 1'b0;
            r_dout   <= 1'b0;
        end else begin
            r_load_q <= load;
            r_dout   <= w_match;
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_seq_8_detector.sv
// Bench for seq_8_detector: vector table, directed corner cases and
// randomized streams checked against a queue-based reference model.
module tb_seq_8_detector;

    localparam int W = 8;

    logic clk;
    logic rst;
    logic load;
    logic din;
    logic dout;

    int n_pass;
    int n_total;

    seq_8_detector #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit l;
        bit d;
        bit exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model: last W loaded bits, length of the current
    // load run, and the detect-mode bits received since load fell.
    bit m_pat[$];
    bit m_hist[$];
    int m_run;
    bit m_prev;
    bit m_exp;
    int pulses;

    function automatic void model_reset();
        m_pat.delete();
        m_hist.delete();
        m_run  = 0;
        m_prev = 1'b0;
        m_exp  = 1'b0;
    endfunction

    function automatic bit model_step(bit l, bit d);
        if (l) begin
            if (!m_prev) begin
                m_pat.delete();
                m_run = 0;
            end
            m_pat.push_back(d);
            if (m_pat.size() > W) void'(m_pat.pop_front());
            m_run++;
            m_hist.delete();
            m_prev = 1'b1;
            return 1'b0;
        end
        m_prev = 1'b0;
        m_hist.push_back(d);
        if (m_hist.size() > W) void'(m_hist.pop_front());
        if (m_run < W || m_hist.size() < W) return 1'b0;
        for (int i = 0; i < W; i++)
            if (m_hist[i] != m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic got,
                         input logic exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: dout=%b expected %b t=%0t",
                     name, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_int(input string name, input int got,
                             input int exp);
        n_total++;
        if (got != exp)
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input bit l, input bit d);
        @(negedge clk);
        load  = l;
        din   = d;
        m_exp = model_step(l, d);
        @(posedge clk);
        #1;
        if (dout === 1'b1) pulses++;
    endtask

    task automatic load_pat(input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, p[7-i]);
            check("load_quiet", dout, 1'b0);
        end
    endtask

    task automatic send(input string name, input logic [15:0] s,
                        input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, s[n-1-i]);
            check(name, dout, m_exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] p33;
        logic [9:0] s55;
        logic [7:0] rp;
        bit         snap[$];
        int         len;

        n_pass  = 0;
        n_total = 0;
        pulses  = 0;
        rst  = 1'b1;
        load = 1'b0;
        din  = 1'b0;
        model_reset();

        // Reset held with toggling inputs
        #1;
        check("reset_t0", dout, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            load = 1'($urandom);
            din  = 1'($urandom);
            @(posedge clk);
            #1;
            check("reset_hold", dout, 1'b0);
        end
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b0;

        // No pattern loaded: never fires
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'($urandom));
            check("no_pattern", dout, 1'b0);
        end

        // Vector table: load 0x33 and match, load 0x55 and overlap
        p33 = 8'h33;
        s55 = 10'b0101010101;
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b1, p33[7-i], 1'b0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b0, p33[7-i], i == 7});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b1, s55[9-i], 1'b0});
        for (int i = 0; i < 10; i++)
            tbl.push_back('{1'b0, s55[9-i], i == 7 || i == 9});
        foreach (tbl[i]) begin
            drive(tbl[i].l, tbl[i].d);
            check("table", dout, tbl[i].exp);
        end

        // Partial load of 5 bits: pattern stays invalid
        load_pat(8'hA8, 5);
        pulses = 0;
        send("partial", 16'b1010_1101_0110_1011, 16);
        check_int("partial_pulses", pulses, 0);

        // Near miss, then reload mid-stream with 0xF0
        load_pat(8'h33, 8);
        pulses = 0;
        send("near_miss", 16'h0032, 8);
        check_int("near_miss_pulses", pulses, 0);
        send("extra_bits", 16'h000C, 4);
        load_pat(8'hF0, 8);
        pulses = 0;
        send("reload_f0", 16'h00F0, 8);
        check_int("reload_pulses", pulses, 1);
        check("reload_last", dout, 1'b1);

        // Asynchronous reset in the middle of a match pulse
        load_pat(8'h33, 8);
        send("pre_rst", 16'h0033, 8);
        check("pre_rst_pulse", dout, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", dout, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        model_reset();
        pulses = 0;
        send("post_rst", 16'h0033, 8);
        check_int("post_rst_pulses", pulses, 0);
        load_pat(8'h33, 8);
        pulses = 0;
        send("reloaded", 16'h0033, 8);
        check_int("reloaded_pulses", pulses, 1);

        // Randomized rounds against the model
        for (int r = 0; r < 12; r++) begin
            rp  = 8'($urandom);
            len = $urandom_range(6, 10);
            for (int i = 0; i < len; i++) begin
                drive(1'b1, 1'($urandom));
                check("rand_load", dout, m_exp);
            end
            snap = m_pat;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    foreach (snap[i]) begin
                        drive(1'b0, snap[i]);
                        check("rand_replay", dout, m_exp);
                    end
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        drive(1'b0, rp[i] ^ 1'($urandom_range(0, 3) == 0));
                        check("rand_noise", dout, m_exp);
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
